bank_cmd_seq: RTL and testbench

BANK_CMD_SEQ -- requirements
Module: bank_cmd_seq

---
 rtl/bank_cmd_seq.sv | 170 +++++++++++++++++
 tb/tb_bank_cmd_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_seq.sv
// Single-bank command sequencer: accepts ACT/RD/WR/PRE, enforces the
// activate-to-access and access-to-data delays, and streams 8-beat bursts
// with sequential column wrap inside the aligned 8-column block.
module bank_cmd_seq #(
   parameter int CHWIDTH  = 5,
   parameter int COLWIDTH = 10,
   parameter int TRCD     = 3,
   parameter int CL       = 4,
   parameter int CWL      = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   input  logic [2:0]          cmd,
   input  logic [CHWIDTH-1:0]  cmd_row,
   input  logic [COLWIDTH-1:0] cmd_col,
   output logic                cmd_ready,
   output logic                rd_o_wr,
   output logic [CHWIDTH-1:0]  row,
   output logic [COLWIDTH-1:0] column,
   output logic                beat_valid,
   output logic                beat_last,
   output logic                row_open,
   output logic                cmd_err
);

   localparam int MAXD = (TRCD > CL) ? ((TRCD > CWL) ? TRCD : CWL)
                                     : ((CL > CWL) ? CL : CWL);
   localparam int CNTW = $clog2(MAXD + 1);

   localparam logic [2:0] C_NOP = 3'd0;
   localparam logic [2:0] C_ACT = 3'd1;
   localparam logic [2:0] C_RD  = 3'd2;
   localparam logic [2:0] C_WR  = 3'd3;
   localparam logic [2:0] C_PRE = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACTIVATING,
      S_OPEN,
      S_RD_WAIT,
      S_WR_WAIT,
      S_BURST_RD,
      S_BURST_WR
   } state_t;

   state_t                state_reg;
   logic [CNTW-1:0]       cnt_reg;
   logic [2:0]            beat_reg;
   logic                  rd_o_wr_reg;
   logic [CHWIDTH-1:0]    row_reg;
   logic [COLWIDTH-1:0]   column_reg;
   logic                  beat_valid_reg;
   logic                  beat_last_reg;
   logic                  row_open_reg;
   logic                  cmd_err_reg;

   // Commands are only taken in the two resting states; decoded from state alone.
   assign cmd_ready = (state_reg == S_IDLE) || (state_reg == S_OPEN);

   // Sequencer state, delay counter and all registered outputs.
   // Each delay counter is loaded with D-1 and the exit fires when it would
   // reach zero, so the follow-on action lands exactly D cycles after acceptance;
   // a delay of 1 skips the waiting state entirely.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         cnt_reg        <= '0;
         beat_reg       <= '0;
         rd_o_wr_reg    <= 1'b0;
         row_reg        <= '0;
         column_reg     <= '0;
         beat_valid_reg <= 1'b0;
         beat_last_reg  <= 1'b0;
         row_open_reg   <= 1'b0;
         cmd_err_reg    <= 1'b0;
      end else begin
         // Non-NOP commands offered while busy are dropped and flagged.
         cmd_err_reg <= cmd_valid && !cmd_ready && (cmd != C_NOP);
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid) begin
                  case (cmd)
                     C_NOP, C_PRE: ;
                     C_ACT: begin
                        row_reg      <= cmd_row;
                        row_open_reg <= 1'b1;
                        if (TRCD == 1) begin
                           state_reg <= S_OPEN;
                        end else begin
                           cnt_reg   <= CNTW'(TRCD - 1);
                           state_reg <= S_ACTIVATING;
                        end
                     end
                     default: cmd_err_reg <= 1'b1;
                  endcase
               end
            end
            S_ACTIVATING: begin
               if (cnt_reg <= CNTW'(1)) begin
                  cnt_reg   <= '0;
                  state_reg <= S_OPEN;
               end else begin
                  cnt_reg <= cnt_reg - CNTW'(1);
               end
            end
            S_OPEN: begin
               if (cmd_valid) begin
                  case (cmd)
                     C_NOP: ;
                     C_RD, C_WR: begin
                        column_reg <= cmd_col;
                        if ((cmd == C_RD) ? (CL == 1) : (CWL == 1)) begin
                           state_reg      <= (cmd == C_WR) ? S_BURST_WR : S_BURST_RD;
                           rd_o_wr_reg    <= (cmd == C_WR);
                           beat_valid_reg <= 1'b1;
                           beat_last_reg  <= 1'b0;
                           beat_reg       <= '0;
                        end else begin
                           cnt_reg   <= (cmd == C_RD) ? CNTW'(CL - 1) : CNTW'(CWL - 1);
                           state_reg <= (cmd == C_RD) ? S_RD_WAIT : S_WR_WAIT;
                        end
                     end
                     C_PRE: begin
                        state_reg    <= S_IDLE;
                        row_open_reg <= 1'b0;
                     end
                     default: cmd_err_reg <= 1'b1;
                  endcase
               end
            end
            S_RD_WAIT, S_WR_WAIT: begin
               if (cnt_reg <= CNTW'(1)) begin
                  cnt_reg        <= '0;
                  state_reg      <= (state_reg == S_WR_WAIT) ? S_BURST_WR : S_BURST_RD;
                  rd_o_wr_reg    <= (state_reg == S_WR_WAIT);
                  beat_valid_reg <= 1'b1;
                  beat_last_reg  <= 1'b0;
                  beat_reg       <= '0;
               end else begin
                  cnt_reg <= cnt_reg - CNTW'(1);
               end
            end
            S_BURST_RD, S_BURST_WR: begin
               if (beat_reg == 3'd7) begin
                  state_reg      <= S_OPEN;
                  beat_valid_reg <= 1'b0;
                  beat_last_reg  <= 1'b0;
                  rd_o_wr_reg    <= 1'b0;
                  beat_reg       <= '0;
               end else begin
                  beat_reg         <= beat_reg + 3'd1;
                  column_reg[2:0]  <= column_reg[2:0] + 3'd1;
                  beat_last_reg    <= (beat_reg == 3'd6);
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign rd_o_wr    = rd_o_wr_reg;
   assign row        = row_reg;
   assign column     = column_reg;
   assign beat_valid = beat_valid_reg;
   assign beat_last  = beat_last_reg;
   assign row_open   = row_open_reg;
   assign cmd_err    = cmd_err_reg;

endmodule

// File: tb/tb_bank_cmd_seq.sv
// Testbench for bank_cmd_seq: directed scenarios followed by random traffic,
// every cycle checked against a timeline model of when each command takes effect.
module tb_bank_cmd_seq;

   localparam int CHW  = 5;
   localparam int COLW = 10;
   localparam int TRCD = 3;
   localparam int CL   = 4;
   localparam int CWL  = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            cmd_valid = 1'b0;
   logic [2:0]      cmd = 3'd0;
   logic [CHW-1:0]  cmd_row = '0;
   logic [COLW-1:0] cmd_col = '0;
   logic            cmd_ready;
   logic            rd_o_wr;
   logic [CHW-1:0]  row;
   logic [COLW-1:0] column;
   logic            beat_valid;
   logic            beat_last;
   logic            row_open;
   logic            cmd_err;

   bank_cmd_seq #(
      .CHWIDTH(CHW), .COLWIDTH(COLW), .TRCD(TRCD), .CL(CL), .CWL(CWL)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
      .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ready(cmd_ready),
      .rd_o_wr(rd_o_wr), .row(row), .column(column), .beat_valid(beat_valid),
      .beat_last(beat_last), .row_open(row_open), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Timeline model: a bank is either closed or open; an open bank accepts
   // commands from m_ready_at onwards; a burst occupies cycles m_bstart..+7.
   bit              m_open = 1'b0;
   int              m_ready_at = 0;
   bit              m_has_b = 1'b0;
   int              m_bstart = 0;
   logic [COLW-1:0] m_bcol = '0;
   bit              m_bwr = 1'b0;
   logic [CHW-1:0]  m_row = '0;
   logic [COLW-1:0] m_col = '0;
   bit              m_err = 1'b0;

   logic [COLW-1:0] lit_cols [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   // Present one cycle of inputs, advance the model and the clock, check all outputs.
   task automatic step(input bit rst, input bit v, input logic [2:0] c,
                       input logic [CHW-1:0] r, input logic [COLW-1:0] col);
      int n;
      int k;
      bit rdy;
      bit ebeat;
      logic [COLW-1:0] ecol;
      logic [2:0] lo;
      reset = rst; cmd_valid = v; cmd = c; cmd_row = r; cmd_col = col;
      n = cyc;
      if (rst) begin
         m_open = 0; m_ready_at = 0; m_has_b = 0; m_row = '0; m_col = '0; m_err = 0;
      end else begin
         rdy = !m_open || (n >= m_ready_at);
         m_err = 0;
         if (v && c != 3'd0) begin
            if (!rdy) m_err = 1;
            else if (!m_open) begin
               if (c == 3'd1) begin
                  m_open = 1; m_row = r; m_ready_at = n + TRCD;
               end else if (c != 3'd4) m_err = 1;
            end else begin
               if (c == 3'd2 || c == 3'd3) begin
                  m_bwr = (c == 3'd3);
                  m_bstart = n + (m_bwr ? CWL : CL);
                  m_has_b = 1; m_bcol = col; m_col = col;
                  m_ready_at = m_bstart + 8;
               end else if (c == 3'd4) m_open = 0;
               else m_err = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      k = cyc - m_bstart;
      ebeat = m_has_b && k >= 0 && k < 8;
      if (m_has_b && k >= 0) begin
         lo = m_bcol[2:0] + 3'((k > 7) ? 7 : k);
         ecol = {m_bcol[COLW-1:3], lo};
      end else begin
         ecol = m_col;
      end
      chk("cmd_ready",  32'(cmd_ready),  32'(!m_open || cyc >= m_ready_at));
      chk("row_open",   32'(row_open),   32'(m_open));
      chk("row",        32'(row),        32'(m_row));
      chk("column",     32'(column),     32'(ecol));
      chk("beat_valid", 32'(beat_valid), 32'(ebeat));
      chk("beat_last",  32'(beat_last),  32'(ebeat && k == 7));
      chk("rd_o_wr",    32'(rd_o_wr),    32'(ebeat && m_bwr));
      chk("cmd_err",    32'(cmd_err),    32'(m_err));
   endtask

   task automatic nop(input int cnt);
      for (int i = 0; i < cnt; i++) step(0, 0, 3'd0, '0, '0);
   endtask

   initial begin
      lit_cols[0] = 10'h00D; lit_cols[1] = 10'h00E; lit_cols[2] = 10'h00F; lit_cols[3] = 10'h008;
      lit_cols[4] = 10'h009; lit_cols[5] = 10'h00A; lit_cols[6] = 10'h00B; lit_cols[7] = 10'h00C;

      // reset, with a command presented during reset that must be ignored
      step(1, 0, 3'd0, '0, '0);
      step(1, 1, 3'd2, '0, 10'h55);
      $display("reset done: cmd_ready=%0d row_open=%0d cmd_err=%0d", cmd_ready, row_open, cmd_err);
      nop(2);

      // ACT row 5, RD 0x00D three cycles later; beats wrap inside the 8-block
      step(0, 1, 3'd1, 5'd5, '0);
      nop(2);
      step(0, 1, 3'd2, '0, 10'h00D);
      for (int i = 1; i <= 11; i++) begin
         step(0, 0, 3'd0, '0, '0);
         if (i >= 3 && i <= 10) begin
            chk("rd_col_literal", 32'(column), 32'(lit_cols[i-3]));
            chk("rd_last_literal", 32'(beat_last), 32'(i == 10));
         end
      end
      $display("read burst done: row=%0d column=0x%03h", row, column);

      // ACT row 2, WR 0x3F8, then back to OPEN
      step(0, 1, 3'd4, '0, '0);
      step(0, 1, 3'd1, 5'd2, '0);
      nop(2);
      step(0, 1, 3'd3, '0, 10'h3F8);
      nop(11);
      $display("write burst done: row=%0d column=0x%03h", row, column);

      // RD one cycle after ACT is rejected
      step(0, 1, 3'd4, '0, '0);
      step(0, 1, 3'd1, 5'd7, '0);
      step(0, 1, 3'd2, '0, 10'h100);
      nop(3);
      $display("early read rejected");

      // RD in IDLE, ACT in OPEN, illegal cmd in OPEN
      step(0, 1, 3'd4, '0, '0);
      step(0, 1, 3'd2, '0, 10'h020);
      nop(1);
      step(0, 1, 3'd1, 5'd9, '0);
      nop(2);
      step(0, 1, 3'd1, 5'd3, '0);
      nop(1);
      step(0, 1, 3'd6, '0, '0);
      nop(1);
      $display("three illegal commands flagged");

      // reset on the 4th write beat abandons the burst
      step(0, 1, 3'd3, '0, 10'h155);
      nop(5);
      step(1, 1, 3'd1, 5'd4, '0);
      nop(1);
      $display("reset mid-burst: beat_valid=%0d row_open=%0d", beat_valid, row_open);

      // PRE in OPEN then PRE in IDLE
      step(0, 1, 3'd1, 5'd1, '0);
      nop(2);
      step(0, 1, 3'd4, '0, '0);
      step(0, 1, 3'd4, '0, '0);
      nop(1);
      $display("double precharge done: row_open=%0d cmd_err=%0d", row_open, cmd_err);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         bit rr;
         bit vv;
         logic [2:0] cc;
         rr = ($urandom_range(0, 99) < 2);
         vv = ($urandom_range(0, 99) < 70);
         cc = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         step(rr, vv, cc, CHW'($urandom), COLW'($urandom));
      end
      $display("random traffic done: cycles=%0d", cyc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
